// File: rtl/filter_conv_param_if.sv
// Sample, coefficient and result bus of the parameterised 2-D convolution filter.
// The master drives windows and coefficients; the slave (the filter) returns q/sat.
interface filter_conv_param_if #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int COFCNT_BIT = 15
);
    localparam int N     = MASK_WIDTH * MASK_WIDTH;
    localparam int IDX_W = $clog2(N);

    logic                         in_valid;
    logic [PIX_BIT*N-1:0]         p;
    logic                         abs_mode;
    logic                         coef_wr;
    logic [IDX_W-1:0]             coef_idx;
    logic signed [COFCNT_BIT-1:0] coef_data;
    logic                         coef_commit;
    logic signed [PIX_BIT:0]      q;
    logic                         out_valid;
    logic                         sat;

    modport master (
        output in_valid, p, abs_mode, coef_wr, coef_idx, coef_data, coef_commit,
        input  q, out_valid, sat
    );

    modport slave (
        input  in_valid, p, abs_mode, coef_wr, coef_idx, coef_data, coef_commit,
        output q, out_valid, sat
    );
endinterface

// File: rtl/filter_conv_param.sv
// MASK_WIDTH x MASK_WIDTH convolution: unsigned pixels times signed coefficients,
// pipelined adder tree, round-half-up, signed or absolute saturation. Double-buffered taps.
module filter_conv_param #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int COFCNT_BIT = 15,
    parameter int FRAC_BIT   = 14
) (
    input logic               clk,
    input logic               reset_n,
    filter_conv_param_if.slave bus
);
    localparam int N      = MASK_WIDTH * MASK_WIDTH;
    localparam int LEVELS = $clog2(N);
    localparam int NP     = 1 << LEVELS;
    localparam int PROD_W = PIX_BIT + COFCNT_BIT + 1;
    localparam int ACC_W  = PROD_W + LEVELS;
    localparam int ACC1   = ACC_W + 1;
    localparam int RND_W  = ACC_W + 1 - FRAC_BIT;
    localparam int RW1    = RND_W + 1;

    localparam logic signed [RND_W:0] Q_MAX  = RW1'((1 << PIX_BIT) - 1);
    localparam logic signed [RND_W:0] Q_MIN  = ~Q_MAX;
    localparam logic [LEVELS:0]       N_CNT  = (LEVELS + 1)'(N);

    function automatic logic signed [ACC_W-1:0] mul_tap(
        input logic [PIX_BIT-1:0]         px,
        input logic signed [COFCNT_BIT-1:0] cf
    );
        logic signed [PROD_W-1:0] a, b, pr;
        a  = PROD_W'($signed({1'b0, px}));
        b  = PROD_W'(cf);
        pr = a * b;
        return ACC_W'(pr);
    endfunction

    function automatic logic signed [RND_W-1:0] round_frac(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] t;
        t = ACC1'(acc) + ACC1'(1 << (FRAC_BIT - 1));
        return t[ACC_W:FRAC_BIT];
    endfunction

    // Returns {clipped, value}; absolute mode folds the sign before clipping.
    function automatic logic [PIX_BIT+1:0] clip(
        input logic signed [RND_W-1:0] v,
        input logic                    abs_m
    );
        logic signed [RND_W:0] w, lo;
        w = RW1'(v);
        if (abs_m && w[RND_W]) w = -w;
        lo = abs_m ? '0 : Q_MIN;
        if (w > Q_MAX) return {1'b1, Q_MAX[PIX_BIT:0]};
        if (w < lo)    return {1'b1, lo[PIX_BIT:0]};
        return {1'b0, w[PIX_BIT:0]};
    endfunction

    logic signed [COFCNT_BIT-1:0] shadow    [N];
    logic signed [COFCNT_BIT-1:0] active    [N];
    logic signed [COFCNT_BIT-1:0] coef_bind [N];

    logic [PIX_BIT*N-1:0]   p_p0;
    logic                   vld_p0;
    logic                   abs_p0;
    logic signed [ACC_W-1:0] tree_p1 [1:2*NP-1];
    logic [LEVELS:0]        vld_tr;
    logic [LEVELS:0]        abs_tr;
    logic [PIX_BIT+1:0]     res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (bus.coef_wr && ({1'b0, bus.coef_idx} < N_CNT))
                shadow[bus.coef_idx] <= bus.coef_data;
            if (bus.coef_commit)
                for (int k = 0; k < N; k++) active[k] <= shadow[k];
        end
    end

    // Taps bind when a sample leaves S0, so a commit on that edge already applies to it.
    always_comb begin
        for (int k = 0; k < N; k++)
            coef_bind[k] = bus.coef_commit ? shadow[k] : active[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            abs_p0 <= 1'b0;
            p_p0   <= '0;
            vld_tr <= '0;
            abs_tr <= '0;
            for (int i = 1; i < 2*NP; i++) tree_p1[i] <= '0;
        end else begin
            // S0: window capture
            vld_p0 <= bus.in_valid;
            abs_p0 <= bus.abs_mode;
            p_p0   <= bus.p;
            // S1: products in the heap leaves, then one tree level per cycle toward node 1
            vld_tr <= {vld_tr[LEVELS-1:0], vld_p0};
            abs_tr <= {abs_tr[LEVELS-1:0], abs_p0};
            for (int k = 0; k < N; k++)
                tree_p1[NP+k] <= mul_tap(p_p0[PIX_BIT*k +: PIX_BIT], coef_bind[k]);
            for (int k = N; k < NP; k++)
                tree_p1[NP+k] <= '0;
            for (int i = 1; i < NP; i++)
                tree_p1[i] <= tree_p1[2*i] + tree_p1[2*i+1];
        end
    end

    assign res = clip(round_frac(tree_p1[1]), abs_tr[LEVELS]);

    // Output stage: q/sat hold between valid samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.sat       <= 1'b0;
            bus.q         <= '0;
        end else begin
            bus.out_valid <= vld_tr[LEVELS];
            if (vld_tr[LEVELS]) begin
                bus.sat <= res[PIX_BIT+1];
                bus.q   <= res[PIX_BIT:0];
            end
        end
    end
endmodule

// File: doc/filter_conv_param.md
FILTER_CONV_PARAM -- requirements
Module: filter_conv_param

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- PIX_BIT, 8, unsigned pixel width.
- MASK_WIDTH, 7, odd kernel side, legal range 3..9.
- COFCNT_BIT, 15, signed two's-complement coefficient width.
- FRAC_BIT, 14, number of fractional coefficient bits dropped at output.
- N, MASK_WIDTH**2, number of taps (derived, not overridable).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  window sample present this cycle.
- p  in  PIX_BIT*N  window pixels, tap k at bits [PIX_BIT*(k+1)-1 : PIX_BIT*k].
- abs_mode  in  1  selects output mode; captured with each sample.
- coef_wr  in  1  shadow-bank write strobe.
- coef_idx  in  clog2(N)  shadow tap index.
- coef_data  in  COFCNT_BIT  coefficient value.
- coef_commit  in  1  copies the shadow bank to the active bank.
- q  out  PIX_BIT+1  signed filter result.
- out_valid  out  1  q valid.
- sat  out  1  result of this sample was clipped.

Function
REQ-003 The block SHALL compute q = sat(round(sum over k of p[k]*c_active[k]) >> FRAC_BIT), with p unsigned and c signed.
REQ-004 Pipeline stages SHALL be: S0 input register (p, in_valid, abs_mode); S1 N signed products of width PIX_BIT+COFCNT_BIT+1; clog2(N) binary adder-tree stages with zero padding to a power of two; final round/saturate register.
REQ-005 Latency SHALL be LAT = 3 + clog2(N) cycles from in_valid to out_valid (9 for N=49, 7 for N=9).
REQ-006 Throughput SHALL be one sample per cycle; the block SHALL have no backpressure and SHALL accept in_valid on every cycle.
REQ-007 A valid bit SHALL travel with each stage; out_valid SHALL equal in_valid delayed by exactly LAT.
REQ-008 The accumulator width SHALL be PIX_BIT+COFCNT_BIT+1+clog2(N), so no intermediate overflow occurs.
REQ-009 Rounding SHALL add 2^(FRAC_BIT-1) before an arithmetic right shift by FRAC_BIT (round half up).
REQ-010 Signed mode (abs_mode=0) SHALL clip to [-2^PIX_BIT, 2^PIX_BIT-1].
REQ-011 Absolute mode (abs_mode=1) SHALL output |x| clipped to [0, 2^PIX_BIT-1].
REQ-012 sat SHALL be 1 exactly when clipping occurred for the sample presented on q, and SHALL be qualified by out_valid.
REQ-013 When out_valid=0, q and sat SHALL hold their previous values.
REQ-014 coef_wr SHALL write coef_data into shadow[coef_idx] at the clock edge.
REQ-015 A coef_wr with coef_idx >= N SHALL be ignored.
REQ-016 coef_commit SHALL copy the whole shadow bank to the active bank at the clock edge.
REQ-017 When coef_wr and coef_commit are asserted in the same cycle, the active bank SHALL receive the shadow contents from before that write; the write SHALL still land in the shadow bank.
REQ-018 Coefficients SHALL be bound to a sample at S1. A sample in S0 during the commit edge SHALL use the new bank; samples at or beyond S1 SHALL use the old bank.
REQ-019 abs_mode SHALL be pipelined with its sample, so changing it mid-stream affects only samples accepted after the change.

Reset
REQ-020 reset_n=0 SHALL immediately and asynchronously clear: all stage valid bits, out_valid, sat, q, all data pipeline registers, and both coefficient banks.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight samples.
REQ-022 After reset_n deasserts, the first out_valid SHALL occur LAT cycles after the first accepted in_valid, and no earlier.
REQ-023 With zeroed coefficients and no commit since reset, every valid output SHALL be q=0, sat=0.

Verification (MASK_WIDTH=3, PIX_BIT=8, COFCNT_BIT=12, FRAC_BIT=8, LAT=7)
REQ-024 Identity: shadow[4]=256, others 0, commit; all pixels 100 -> q=100, sat=0, out_valid exactly 7 cycles after in_valid.
REQ-025 Saturation: all coefficients 256, all pixels 255 (sum 2295) -> q=255, sat=1; same input with abs_mode=1 -> q=255, sat=1.
REQ-026 Laplacian: center -2048, others 256; pixels 10, center 20 -> q=-80, sat=0; abs_mode=1 -> q=80; center 200 -> q=-256, sat=1.
REQ-027 Rounding: center coefficient 128, others 0; pixel 3 -> q=2; pixel 2 -> q=1.
REQ-028 Commit mid-stream: continuous in_valid, coefficients switched from identity to 2x (512) by a commit during the stream; pixels 50 -> outputs show 50 up to the cutover sample defined by REQ-018, then 100, with no gap in out_valid; simultaneous coef_wr/commit per REQ-017.
REQ-029 Reset mid-stream: assert reset_n=0 for 1 cycle with 5 samples in flight -> out_valid, q and sat drop to 0 at once; no flushed sample appears afterward; coefficients read back as 0 (q=0).
